// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg : shared op/state encodings and width default for mul_div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic mdu_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_e op);
        return op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if : command, MTHI/MTLO and result bundle of the mul/div unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mul_div_unit_if #(
    parameter int unsigned WIDTH = mdu_pkg::MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step : one radix-2 iteration (shift-add multiply / restoring divide)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic               is_div_i,
    input  wire logic [2*WIDTH-1:0] acc_i,
    input  wire logic [WIDTH-1:0]   operand_i,
    output logic      [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
    // Divide:   acc = {partial remainder, dividend/quotient bits}, shifts left.
    always_comb begin
        mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                  + (acc_i[0] ? {1'b0, operand_i} : '0);
        div_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand_i});
        div_diff  = div_shift - {1'b0, operand_i};
        if (is_div_i) begin
            acc_o = div_ge ? {div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : iterative MULT/MULTU/DIV/DIVU with private HI/LO registers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mul_div_unit_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e         state_q;
    mdu_op_e            op_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [2*WIDTH-1:0] step_acc;
    mdu_op_e            op_in;
    logic               in_signed;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (mdu_is_div(op_q)),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    always_comb begin
        op_in     = mdu_op_e'(bus.op);
        in_signed = mdu_is_signed(op_in);
        in_neg_a  = in_signed & bus.src_a[WIDTH-1];
        in_neg_b  = in_signed & bus.src_b[WIDTH-1];
        mag_a     = in_neg_a ? -bus.src_a : bus.src_a;
        mag_b     = in_neg_b ? -bus.src_b : bus.src_b;
    end

    // Sign flags are only ever set for signed ops, so no op check is needed here.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (mdu_is_div(op_q)) begin
            // A zero divisor leaves the dividend as remainder, so hi already holds src_a.
            res_hi = rem_fix;
            res_lo = (opnd_q == '0) ? '1 : quot_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULTU;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q    <= op_in;
                        neg_a_q <= in_neg_a;
                        neg_b_q <= in_neg_b;
                        opnd_q  <= mdu_is_div(op_in) ? mag_b : mag_a;
                        acc_q   <= mdu_is_div(op_in) ? {{WIDTH{1'b0}}, mag_a}
                                                     : {{WIDTH{1'b0}}, mag_b};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                ST_CALC: begin
                    acc_q <= step_acc;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire
